// File: rtl/serial_frame_router_if.sv
// Serial frame router bus: strobed serial input plus per-channel serial outputs and status.
//   clk_en         bit strobe from the pin logic
//   ser_in         serial data in
//   ser_out        per-channel serial data out (NUM_CH wide)
//   ser_out_valid  per-channel data-valid, at most one bit set
//   busy           frame in progress (ADDR/LEN/DATA/DONE)
//   done           one-cycle end-of-frame pulse
//   frame_cnt      completed-frame count
// master: the stream source and consumers side; slave: the router.
interface serial_frame_router_if #(
  parameter int unsigned CH_BITS = 2,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned NUM_CH = 2 ** CH_BITS;

  logic              clk_en;
  logic              ser_in;
  logic [NUM_CH-1:0] ser_out;
  logic [NUM_CH-1:0] ser_out_valid;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output clk_en, ser_in,
    input  ser_out, ser_out_valid, busy, done, frame_cnt
  );

  modport slave (
    input  clk_en, ser_in,
    output ser_out, ser_out_valid, busy, done, frame_cnt
  );
endinterface

// File: rtl/serial_frame_router.sv
// Serial frame router: hunts a programmable sync pattern on a strobed 1-bit stream, reads a
// channel address and a payload length (MSB first), then steers len+1 payload bits to the
// addressed serial output with zero latency.
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  serial_frame_router_if slave modport (clk_en, ser_in in; ser_out, ser_out_valid,
//        busy, done, frame_cnt out)
module serial_frame_router #(
  parameter int unsigned          PAT_LEN  = 6,
  parameter logic [PAT_LEN-1:0]   PATTERN  = 6'b110101,
  parameter int unsigned          CH_BITS  = 2,
  parameter int unsigned          LEN_BITS = 4,
  parameter int unsigned          CNT_W    = 8
) (
  input logic                  clk,
  input logic                  rst,
  serial_frame_router_if.slave bus
);

  localparam int unsigned NUM_CH = 2 ** CH_BITS;
  localparam int unsigned HIST_W = PAT_LEN - 1;
  localparam int unsigned FILL_W = $clog2(PAT_LEN);
  localparam int unsigned ABIT_W = $clog2(CH_BITS + 1);
  localparam int unsigned LBIT_W = $clog2(LEN_BITS + 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  logic [HIST_W-1:0]   hist;
  logic [FILL_W-1:0]   fill;
  logic [CH_BITS-1:0]  addr;
  logic [LEN_BITS-1:0] len;
  logic [ABIT_W-1:0]   abit;
  logic [LBIT_W-1:0]   lbit;
  logic [LEN_BITS-1:0] pcnt;
  logic [CNT_W-1:0]    frame_cnt;
  logic                done_q;
  logic                busy_q;

  logic [PAT_LEN-1:0]  window;
  logic                match;
  logic [NUM_CH-1:0]   out_c;
  logic [NUM_CH-1:0]   valid_c;

  // Sliding window over the last PAT_LEN bits; fill guards against matching on stale zeros.
  assign window = {hist, bus.ser_in};
  assign match  = (window == PATTERN) && (fill == FILL_W'(HIST_W));

  // Frame FSM with its datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HUNT;
      hist      <= '0;
      fill      <= '0;
      addr      <= '0;
      len       <= '0;
      abit      <= '0;
      lbit      <= '0;
      pcnt      <= '0;
      frame_cnt <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_HUNT: begin
          if (bus.clk_en) begin
            hist <= window[HIST_W-1:0];
            if (fill != FILL_W'(HIST_W)) begin
              fill <= fill + FILL_W'(1);
            end
            if (match) begin
              state  <= S_ADDR;
              abit   <= '0;
              busy_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (bus.clk_en) begin
            addr <= CH_BITS'({addr, bus.ser_in});
            if (abit == ABIT_W'(CH_BITS - 1)) begin
              state <= S_LEN;
              lbit  <= '0;
            end else begin
              abit <= abit + ABIT_W'(1);
            end
          end
        end
        S_LEN: begin
          if (bus.clk_en) begin
            len <= LEN_BITS'({len, bus.ser_in});
            if (lbit == LBIT_W'(LEN_BITS - 1)) begin
              state <= S_DATA;
              pcnt  <= '0;
            end else begin
              lbit <= lbit + LBIT_W'(1);
            end
          end
        end
        S_DATA: begin
          // The routing itself is combinational; here only the payload bits are counted.
          if (bus.clk_en) begin
            if (pcnt == len) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              pcnt <= pcnt + LEN_BITS'(1);
            end
          end
        end
        S_DONE: begin
          // Unconditional single cycle; the history is wiped so no match spans two frames.
          frame_cnt <= frame_cnt + CNT_W'(1);
          hist      <= '0;
          fill      <= '0;
          state     <= S_HUNT;
          busy_q    <= 1'b0;
        end
        default: begin
          state  <= S_HUNT;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency payload steering; unselected lanes and all lanes outside DATA drive 0.
  always_comb begin
    out_c   = '0;
    valid_c = '0;
    if (rst && bus.clk_en && (state == S_DATA)) begin
      valid_c[addr] = 1'b1;
      out_c[addr]   = bus.ser_in;
    end
  end

  // Status is forced low while reset is held, including before the first reset edge.
  assign bus.ser_out       = out_c;
  assign bus.ser_out_valid = valid_c;
  assign bus.busy          = rst & busy_q;
  assign bus.done          = rst & done_q;
  assign bus.frame_cnt     = frame_cnt;

endmodule

// File: tb/tb_serial_frame_router.sv
// Bench for serial_frame_router: directed frames; payload and done expectations are queued
// by the driver and checked by an independent negedge monitor.
module tb_serial_frame_router;

  localparam int unsigned CH_BITS = 2;
  localparam int unsigned CNT_W   = 8;

  logic clk;
  logic rst;

  serial_frame_router_if #(.CH_BITS(CH_BITS), .CNT_W(CNT_W)) bus ();

  serial_frame_router #(
    .PAT_LEN  (6),
    .PATTERN  (6'b110101),
    .CH_BITS  (CH_BITS),
    .LEN_BITS (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_tests;
  int         n_fail;
  int         exp_q[$];   // payload bit expectations: channel*2 + bit
  int         done_q[$];  // frame_cnt expected while done is high
  logic [7:0] exp_frames;
  int         mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid lane must match the next queued payload bit; every done pulse
  // must match the next queued frame count.
  always @(negedge clk) begin
    if (bus.ser_out_valid !== '0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=%b with no payload pending", bus.ser_out_valid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("lane_valid", 32'(bus.ser_out_valid), 32'(1) << (mon_e >> 1));
        chk("lane_data", 32'(bus.ser_out), 32'(mon_e & 1) << (mon_e >> 1));
      end
    end else begin
      chk("idle_data", 32'(bus.ser_out), 32'd0);
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done high with no frame pending (t=%0t)", $time);
      end else begin
        mon_e = done_q.pop_front();
        chk("done_frame_cnt", 32'(bus.frame_cnt), 32'(mon_e));
      end
    end
  end

  // One enabled bit; in gapped mode it is followed by a disabled cycle carrying junk.
  task automatic drive(input logic b, input bit gap, input bit push, input int code);
    @(posedge clk); #1;
    bus.clk_en = 1'b1;
    bus.ser_in = b;
    if (push) exp_q.push_back(code);
    if (gap) begin
      @(posedge clk); #1;
      bus.clk_en = 1'b0;
      bus.ser_in = ~b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.clk_en = 1'b0;
      bus.ser_in = 1'b0;
    end
  endtask

  // Preamble (pattern, possibly with leading bits), address, length, payload pay[l..0].
  task automatic send_frame(input logic [15:0] pre, input int pre_len, input logic [1:0] a,
                            input logic [3:0] l, input logic [15:0] pay, input bit gap);
    for (int i = pre_len - 1; i >= 0; i--) drive(pre[i], gap, 1'b0, 0);
    drive(a[1], gap, 1'b0, 0);
    @(negedge clk);
    chk("busy_in_frame", 32'(bus.busy), 32'd1);
    drive(a[0], gap, 1'b0, 0);
    for (int i = 3; i >= 0; i--) drive(l[i], gap, 1'b0, 0);
    for (int i = int'(l); i >= 0; i--) drive(pay[i], gap, 1'b1, int'(a) * 2 + int'(pay[i]));
    done_q.push_back(int'(exp_frames));
    exp_frames++;
    // DONE cycle: a 1 here would start a pattern if the router wrongly sampled it.
    if (!gap) drive(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    logic [11:0] hdr;
    n_tests    = 0;
    n_fail     = 0;
    exp_frames = 8'd0;
    rst        = 1'b0;
    bus.clk_en = 1'b1;
    bus.ser_in = 1'b0;

    // Reset held for two cycles with random data
    repeat (2) begin
      @(posedge clk); #1;
      bus.ser_in = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_valid", 32'(bus.ser_out_valid), 32'd0);
    chk("rst_out", 32'(bus.ser_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.clk_en = 1'b0;

    // Basic frame: channel 2, payload 1,0,1,1
    send_frame(16'b110101, 6, 2'b10, 4'b0011, 16'b1011, 1'b0);
    idle(1);
    @(negedge clk);
    chk("basic_frame_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("basic_busy_after", 32'(bus.busy), 32'd0);

    // Overlapping false start: 1110101 matches on its 7th bit
    send_frame(16'b1110101, 7, 2'b01, 4'b0000, 16'b1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("overlap_frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Gapped strobe: same frame as basic with clk_en alternating
    send_frame(16'b110101, 6, 2'b10, 4'b0011, 16'b1011, 1'b1);
    idle(1);
    @(negedge clk);
    chk("gapped_frame_cnt", 32'(bus.frame_cnt), 32'd3);

    // Pattern tail right after a frame must not combine with the previous frame's history
    send_frame(16'b10101_110101, 11, 2'b11, 4'b0001, 16'b01, 1'b0);
    idle(1);
    @(negedge clk);
    chk("nocross_frame_cnt", 32'(bus.frame_cnt), 32'd4);

    // Mid-frame reset during the 2nd payload bit
    hdr = 12'b110101_10_0011;
    for (int i = 11; i >= 0; i--) drive(hdr[i], 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b1, 2 * 2 + 1);
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.clk_en = 1'b1;
    bus.ser_in = 1'b1;
    @(negedge clk);
    chk("midrst_valid_during", 32'(bus.ser_out_valid), 32'd0);
    @(posedge clk); #1;
    rst        = 1'b1;
    bus.clk_en = 1'b1;
    bus.ser_in = 1'b0;
    exp_frames = 8'd0;
    @(negedge clk);
    chk("midrst_valid_after", 32'(bus.ser_out_valid), 32'd0);
    chk("midrst_busy_after", 32'(bus.busy), 32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    send_frame(16'b110101, 6, 2'b10, 4'b0011, 16'b1011, 1'b0);
    idle(1);
    @(negedge clk);
    chk("postrst_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Max length, 256 back-to-back frames: counter wraps to 0
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b1;
    exp_frames = 8'd0;
    for (int i = 0; i < 256; i++) begin
      send_frame(16'b110101, 6, 2'(i), 4'hF, 16'(i * 32'h9E37 ^ 32'h5A5A), 1'b0);
    end
    idle(1);
    @(negedge clk);
    chk("wrap_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("wrap_busy_after", 32'(bus.busy), 32'd0);

    idle(3);
    @(negedge clk);
    chk("payload_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
